// File: rtl/msgencode_mux_if.sv
// msgencode_mux_if: stream-side and tx-side signal bundle for the message encoder mux
// Ports (via modports):
//   master - encoder view: consumes strm_data/strm_count/strm_avail/tx_pull,
//            drives strm_pull/send_id/tx_data/tx_avail
//   slave  - environment view: the opposite directions
interface msgencode_mux_if #(
   parameter int NUM_CHAN = 4
);
   logic [8*NUM_CHAN-1:0]  strm_data;
   logic [10*NUM_CHAN-1:0] strm_count;
   logic [NUM_CHAN-1:0]    strm_avail;
   logic [NUM_CHAN-1:0]    strm_pull;
   logic [3:0]             send_id;
   logic [7:0]             tx_data;
   logic                   tx_avail;
   logic                   tx_pull;
   modport master (
      input  strm_data, strm_count, strm_avail, tx_pull,
      output strm_pull, send_id, tx_data, tx_avail
   );
   modport slave (
      output strm_data, strm_count, strm_avail, tx_pull,
      input  strm_pull, send_id, tx_data, tx_avail
   );
endinterface

// File: rtl/msgencode_mux.sv
// msgencode_mux: round-robin multi-stream tx message framer with optional idle heartbeat
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset
//   bus  - msgencode_mux_if.master: per-channel data/count/avail in, one-hot strm_pull out,
//          framed byte stream out (tx_data/tx_avail with tx_pull acceptance), send_id of frame
// Frame: HDR {0110,id}, SEQ {count[1:0],seq}, DATALEN count[9:2], DATA x count, CRC0, CRC1, TERM
module msgencode_mux #(
   parameter int         NUM_CHAN  = 4,
   parameter int         HB_CYCLES = 0,
   parameter logic [3:0] HB_ID     = 4'hf,
   parameter logic [7:0] SCAN_CHAR = 8'h7e
) (
   input logic           clk,
   input logic           rst,
   msgencode_mux_if.master bus
);
   typedef enum logic [2:0] {IDLE, HDR, SEQ, DATALEN, DATA, CRC0, CRC1, TERM} state_t;
   state_t      state, state_n;
   logic [5:0]  seq;
   logic [3:0]  rr_last;
   logic [3:0]  gnt;
   logic        gnt_ok;
   logic        hb_fire;
   logic [31:0] hb_cnt;
   logic [9:0]  count;
   logic [9:0]  sel_count;
   logic [7:0]  data_q;
   logic [7:0]  sel_data;
   logic [7:0]  tx_byte;
   logic [15:0] crc;
   logic        pull_en;

   // crc16 ccitt, poly 0x1021, msb first, preset 0xffff
   function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] d);
      logic [15:0] r;
      logic        fb;
      r = c;
      for (int b = 7; b >= 0; b--) begin
         fb = r[15] ^ d[b];
         r  = {r[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
      end
      return r;
   endfunction

   // Two passes: the lowest requester above rr_last wins, otherwise the lowest overall (wrap).
   always_comb begin
      gnt    = '0;
      gnt_ok = 1'b0;
      for (int i = NUM_CHAN - 1; i >= 0; i--)
         if (bus.strm_avail[i]) begin
            gnt    = 4'(i);
            gnt_ok = 1'b1;
         end
      for (int i = NUM_CHAN - 1; i >= 0; i--)
         if (bus.strm_avail[i] && 4'(i) > rr_last) gnt = 4'(i);
   end

   always_comb begin
      sel_count = '0;
      sel_data  = '0;
      for (int i = 0; i < NUM_CHAN; i++) begin
         if (gnt == 4'(i)) sel_count = bus.strm_count[10*i +: 10];
         if (bus.send_id == 4'(i)) sel_data = bus.strm_data[8*i +: 8];
      end
   end

   // A stream request on the trigger cycle takes priority over the heartbeat.
   assign hb_fire = (HB_CYCLES != 0) && !gnt_ok && hb_cnt == 32'(HB_CYCLES - 1);

   always_comb begin
      state_n = state;
      tx_byte = 8'h00;
      pull_en = 1'b0;
      case (state)
         IDLE:    state_n = (gnt_ok || hb_fire) ? HDR : IDLE;
         HDR: begin
            tx_byte = {4'b0110, bus.send_id};
            state_n = bus.tx_pull ? SEQ : HDR;
         end
         SEQ: begin
            tx_byte = {count[1:0], seq};
            state_n = bus.tx_pull ? DATALEN : SEQ;
         end
         DATALEN: begin
            tx_byte = count[9:2];
            pull_en = bus.tx_pull && count != 10'd0;
            state_n = !bus.tx_pull ? DATALEN : (count == 10'd0 ? CRC0 : DATA);
         end
         DATA: begin
            tx_byte = data_q;
            pull_en = bus.tx_pull && count != 10'd1;
            state_n = (bus.tx_pull && count == 10'd1) ? CRC0 : DATA;
         end
         CRC0: begin
            tx_byte = crc[15:8];
            state_n = bus.tx_pull ? CRC1 : CRC0;
         end
         CRC1: begin
            tx_byte = crc[7:0];
            state_n = bus.tx_pull ? TERM : CRC1;
         end
         TERM: begin
            tx_byte = SCAN_CHAR;
            state_n = bus.tx_pull ? IDLE : TERM;
         end
         default: state_n = IDLE;
      endcase
   end

   // Heartbeat frames carry HB_ID >= NUM_CHAN, so no pull bit can match them.
   always_comb begin
      bus.strm_pull = '0;
      for (int i = 0; i < NUM_CHAN; i++)
         bus.strm_pull[i] = pull_en && bus.send_id == 4'(i);
   end

   assign bus.tx_data  = tx_byte;
   assign bus.tx_avail = state != IDLE;

   always_ff @(posedge clk)
      if (rst)
         state <= IDLE;
      else
         state <= state_n;

   always_ff @(posedge clk)
      if (rst) begin
         seq         <= '0;
         rr_last     <= 4'(NUM_CHAN - 1);
         hb_cnt      <= '0;
         bus.send_id <= '0;
         count       <= '0;
         data_q      <= '0;
         crc         <= 16'hffff;
      end else begin
         if (state == IDLE) begin
            crc <= 16'hffff;
            if (gnt_ok) begin
               rr_last     <= gnt;
               bus.send_id <= gnt;
               count       <= sel_count;
               seq         <= seq + 6'd1;
               hb_cnt      <= '0;
            end else if (hb_fire) begin
               bus.send_id <= HB_ID;
               count       <= '0;
               seq         <= seq + 6'd1;
               hb_cnt      <= '0;
            end else if (HB_CYCLES != 0)
               hb_cnt <= hb_cnt + 32'd1;
         end else if (bus.tx_pull) begin
            if (state inside {HDR, SEQ, DATALEN, DATA}) crc <= crc_step(crc, tx_byte);
            if (state == DATA) count <= count - 10'd1;
         end
         if (pull_en) data_q <= sel_data;
      end
endmodule

// File: tb/tb_msgencode_mux.sv
// tb_msgencode_mux: scoreboard bench for msgencode_mux (4 channels, heartbeat after 100 idle cycles)
module tb_msgencode_mux;
   localparam int NC = 4;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   msgencode_mux_if #(.NUM_CHAN(NC)) bus ();
   msgencode_mux #(.NUM_CHAN(NC), .HB_CYCLES(100), .HB_ID(4'hf), .SCAN_CHAR(8'h7e)) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );

   int         checks = 0;
   int         errors = 0;
   logic [7:0] exp_q[$];
   logic [7:0] src_q[NC][$];
   logic [9:0] cnt[NC];
   int         msgs_left[NC];
   int         exp_pulls[NC];
   int         pulls_seen[NC];
   logic [5:0] exp_seq = '0;
   logic [NC-1:0] pend = '0;
   logic       prev_avail = 1'b0;
   int         idle_run = 0;
   int         last_idle = 0;
   int         rx_cnt = 0;
   int         arm_idle = 0;
   int         arm_ch = 0;
   bit         pull_rand = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] d);
      logic [15:0] r;
      r = c ^ {d, 8'h00};
      repeat (8) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
      return r;
   endfunction

   task automatic update_src();
      for (int i = 0; i < NC; i++) begin
         bus.strm_data[8*i +: 8]   = src_q[i].size() != 0 ? src_q[i][0] : 8'h00;
         bus.strm_count[10*i +: 10] = cnt[i];
         bus.strm_avail[i]          = msgs_left[i] != 0;
      end
   endtask

   task automatic push_frame(input logic [3:0] id, input logic [7:0] d[$]);
      logic [7:0]  f[$];
      logic [15:0] c;
      logic [9:0]  n;
      n = 10'(d.size());
      exp_seq++;
      f.push_back({4'b0110, id});
      f.push_back({n[1:0], exp_seq});
      f.push_back(n[9:2]);
      foreach (d[k]) f.push_back(d[k]);
      c = 16'hffff;
      foreach (f[k]) c = crc_upd(c, f[k]);
      f.push_back(c[15:8]);
      f.push_back(c[7:0]);
      f.push_back(8'h7e);
      foreach (f[k]) exp_q.push_back(f[k]);
   endtask

   task automatic add_msg(input int ch, input logic [7:0] d[$], input bit armed);
      foreach (d[k]) src_q[ch].push_back(d[k]);
      cnt[ch] = 10'(d.size());
      exp_pulls[ch] += d.size();
      push_frame(4'(ch), d);
      if (!armed) msgs_left[ch]++;
      update_src();
   endtask

   function automatic void rand_bytes(input int n, output logic [7:0] d[$]);
      d.delete();
      for (int k = 0; k < n; k++) d.push_back(8'($urandom));
   endfunction

   task automatic wait_done(input string tag, input int maxc);
      int n = 0;
      while (exp_q.size() != 0 && n < maxc) begin
         @(negedge clk);
         #2;
         n++;
      end
      check({tag, "_left"}, 32'(exp_q.size()), 0);
      exp_q.delete();
      for (int i = 0; i < NC; i++) check({tag, "_pulls"}, 32'(pulls_seen[i]), 32'(exp_pulls[i]));
   endtask

   initial begin
      bus.tx_pull = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         bus.tx_pull = pull_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Source model, scoreboard and idle/grant tracking, all sampled mid-cycle.
   always @(negedge clk) begin
      if (rst) begin
         pend       = '0;
         prev_avail = 1'b0;
         idle_run   = 0;
      end else begin
         for (int i = 0; i < NC; i++)
            if (pend[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
         pend = bus.strm_pull;
         for (int i = 0; i < NC; i++) if (pend[i]) pulls_seen[i]++;
         if (pend != '0) check("pull_sel", 32'(pend), 32'(1) << bus.send_id);
         if (bus.tx_avail) begin
            if (!prev_avail) begin
               last_idle = idle_run;
               idle_run  = 0;
               if (exp_q.size() != 0) check("send_id", 32'(bus.send_id), 32'(exp_q[0][3:0]));
               if (bus.send_id < NC && msgs_left[bus.send_id] != 0) msgs_left[bus.send_id]--;
            end
            if (exp_q.size() == 0)
               check("extra_byte", 32'(bus.tx_data), 32'h100);
            else if (bus.tx_pull) begin
               check("tx_byte", 32'(bus.tx_data), 32'(exp_q.pop_front()));
               rx_cnt++;
            end else
               check("stall", 32'(bus.tx_data), 32'(exp_q[0]));
         end else begin
            idle_run++;
            if (arm_idle != 0 && idle_run == arm_idle) begin
               msgs_left[arm_ch] = 1;
               arm_idle = 0;
            end
         end
         prev_avail = bus.tx_avail;
         update_src();
      end
   end

   task automatic clear_model();
      exp_q.delete();
      for (int i = 0; i < NC; i++) begin
         src_q[i].delete();
         cnt[i]        = '0;
         msgs_left[i]  = 0;
         exp_pulls[i]  = 0;
         pulls_seen[i] = 0;
      end
      exp_seq = '0;
      update_src();
   endtask

   initial begin
      logic [7:0] d[$];
      clear_model();
      repeat (2) @(posedge clk);
      #1;
      check("rst_avail", 32'(bus.tx_avail), 0);
      check("rst_pull", 32'(bus.strm_pull), 0);
      check("rst_id", 32'(bus.send_id), 0);
      rst = 1'b0;

      // round robin: ch0 and ch2 both pending, ids alternate starting at ch0
      for (int r = 0; r < 2; r++) begin
         rand_bytes(1, d); add_msg(0, d, 1'b0);
         rand_bytes(1, d); add_msg(2, d, 1'b0);
      end
      wait_done("rr", 200);

      // single channel, three known bytes
      d = '{8'h11, 8'h22, 8'h33};
      add_msg(1, d, 1'b0);
      wait_done("single", 100);

      // 64 zero-length frames wrap the 6-bit sequence
      d.delete();
      for (int r = 0; r < 64; r++) add_msg(3, d, 1'b0);
      wait_done("zero", 2000);

      // maximum length with random sink stalls
      pull_rand = 1'b1;
      rand_bytes(1023, d);
      add_msg(2, d, 1'b0);
      wait_done("max", 10000);
      pull_rand = 1'b0;

      // heartbeat after 100 idle cycles
      d.delete();
      push_frame(4'hf, d);
      wait_done("hb", 300);
      check("hb_idle", 32'(last_idle), 100);

      // stream raised on the heartbeat trigger cycle wins, then heartbeat timer restarts
      arm_ch = 1;
      arm_idle = 100;
      rand_bytes(2, d);
      add_msg(1, d, 1'b1);
      wait_done("hb_pre", 300);
      check("pre_idle", 32'(last_idle), 100);
      d.delete();
      push_frame(4'hf, d);
      wait_done("hb2", 300);
      check("hb2_idle", 32'(last_idle), 100);

      // reset in the middle of a data phase
      rx_cnt = 0;
      rand_bytes(10, d);
      add_msg(0, d, 1'b0);
      for (int n = 0; n < 200 && rx_cnt < 7; n++) begin
         @(negedge clk);
         #2;
      end
      check("pre_rst_rx", 32'(rx_cnt >= 7), 1);
      @(posedge clk);
      #1;
      rst = 1'b1;
      clear_model();
      @(posedge clk);
      #1;
      check("mid_rst_avail", 32'(bus.tx_avail), 0);
      check("mid_rst_pull", 32'(bus.strm_pull), 0);
      rst = 1'b0;
      rand_bytes(2, d); add_msg(0, d, 1'b0);
      rand_bytes(2, d); add_msg(2, d, 1'b0);
      wait_done("post_rst", 200);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/msgencode_mux.md
Name: msgencode_mux

Overview:
- Multi-channel successor to the single-stream tx message encoder.
- Arbitrates round-robin among NUM_CHAN tx data streams and frames each granted stream as one serial message: HDR, SEQ, DATALEN, DATA x N, CRC0, CRC1, TERM.
- Adds zero-length message support and an optional idle heartbeat frame.
- Sits between the per-source stream FIFOs and the uart/usb tx byte sink.

Parameters:
- NUM_CHAN, 4, number of input streams (1..15); channel i is sent with stream id i.
- HB_CYCLES, 0, idle cycles before a heartbeat frame is emitted; 0 disables heartbeats.
- HB_ID, 4'hf, stream id used in the heartbeat header; must be >= NUM_CHAN.
- SCAN_CHAR, 8'h7e, terminator byte.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- strm_data  input  8*NUM_CHAN  per-channel next payload byte; channel i is at [8i+7:8i]
- strm_count  input  10*NUM_CHAN  per-channel payload length in bytes (0..1023); channel i is at [10i+9:10i]
- strm_avail  input  NUM_CHAN  channel has a complete message ready
- strm_pull  output  NUM_CHAN  consume one byte from the channel (at most one bit high, combinational)
- send_id  output  4  id of the frame currently or last sent
- tx_data  output  8  current tx byte (combinational from state)
- tx_avail  output  1  tx_data valid
- tx_pull  input  1  sink accepted tx_data this cycle

Behaviour:
- Reset (clk edge with rst=1): state=IDLE, seq=0, rr_last=NUM_CHAN-1 (channel 0 wins first), hb_cnt=0, send_id=0, tx_avail=0, strm_pull=0. rst overrides all other inputs. Reset mid-frame abandons the frame: tx_avail is low the cycle after the reset edge, and no CRC/TERM is sent.
- States: IDLE, HDR, SEQ, DATALEN, DATA, CRC0, CRC1, TERM. tx_avail = (state != IDLE). tx_pull is ignored in IDLE.
- IDLE grant: the first channel with strm_avail set, searching from (rr_last+1) mod NUM_CHAN upward with wrap. On grant:
  - rr_last=ch, send_id=ch, count latched from that channel, seq=seq+1 (6-bit wrap 63->0), state=HDR.
  - Grant-to-HDR latency is 1 cycle.
  - strm_avail of the granted channel is ignored until the frame ends.
- Heartbeat (only when HB_CYCLES>0):
  - hb_cnt increments each IDLE cycle with no strm_avail bit set.
  - When hb_cnt==HB_CYCLES-1 and still no avail: start a frame with send_id=HB_ID, count=0, seq incremented; rr_last is unchanged.
  - hb_cnt clears to 0 whenever any frame starts.
  - If any strm_avail is set on the trigger cycle, the stream wins.
- Byte sequence, advancing one state per tx_pull:
  - HDR = {4'b0110, send_id}
  - SEQ = {count[1:0], seq}
  - DATALEN = count[9:2]
  - DATA = latched byte
  - CRC0 = crc[15:8]
  - CRC1 = crc[7:0]
  - TERM = SCAN_CHAR; TERM -> IDLE.
- DATALEN transitions:
  - count==0: DATALEN -> CRC0, DATA is skipped, no strm_pull.
  - Otherwise DATALEN -> DATA.
- DATA: stays in DATA until the byte sent with count==1; count decrements on each DATA tx_pull.
- strm_pull[send_id] = tx_pull && (state==DATALEN && count!=0 || state==DATA && count!=1).
  - Never asserted during heartbeat frames.
  - Exactly count pulls per frame.
  - The pulled strm_data byte is registered and presented in the next DATA byte.
- CRC: uses the existing crc16ccitt block, cleared while IDLE, fed tx_data on every tx_pull in HDR..DATA. CRC bytes and TERM are not included.
- tx_pull stalls: while tx_pull=0 the state, tx_data and the latched data byte are held indefinitely.
- Back-to-back: the cycle after the TERM pull is IDLE, so there is a minimum 1 idle cycle between frames.

Test Plan:
- Single channel: ch1 avail, count=3, bytes 11,22,33, tx_pull held 1 -> tx_data 61,C1,00,11,22,33,crcH,crcL,7E. Exactly 3 strm_pull[1] pulses. CRC matches the crc16ccitt model. seq=1.
- Round-robin: ch0 and ch2 avail continuously, 1-byte messages -> frame ids alternate 0,2,0,2. seq increments 1,2,3,4. No starvation.
- Zero-length and wrap: count=0 -> HDR, SEQ, DATALEN=00, CRC0, CRC1, 7E with no strm_pull. Repeated 64 times -> seq wraps 63->0.
- Max length with random tx_pull gaps: count=1023 -> DATALEN=FF, SEQ[7:6]=11. 1023 data bytes in order. tx_data is stable across every stall cycle.
- Heartbeat (HB_CYCLES=100): idle -> frame 6F, seq, 00, crc, 7E on cycle 100. A strm_avail raised on cycle 99 wins instead, and hb_cnt restarts.
- Reset mid-DATA (count=10, after 4 bytes): next cycle tx_avail=0 and seq=0. The following grant goes to ch0 first, and the new frame is byte-correct.
